poly_stream_decoder: RTL and testbench

Next-generation polynomial decoder. It accepts a full frame of POLY_SIZE scaled coefficients over a valid/ready handshake and stores it in a frame buffer. It then streams out every coefficient, reverse-scaled by SCALE_FACTOR, as LANES words per beat with its own valid/ready handshake. It sits between the encoder/coefficient datapath and the binary sink, replacing the single-coefficient combinational decode.

---
 rtl/poly_codec_pkg.sv | 23 ++
 rtl/poly_stream_decoder_if.sv | 38 +++
 rtl/poly_coeff_rescale.sv | 55 +++++
 rtl/poly_stream_decoder.sv | 104 ++++++++++
 tb/tb_poly_stream_decoder.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/poly_codec_pkg.sv
// Shared polynomial codec definitions, used by the decoder here and by the
// encoder side of the datapath.
//   coeff_width : width of one scaled coefficient (OUTPUT_WIDTH + SCALE_FACTOR)
//   beats       : output beats per frame (POLY_SIZE / LANES)
//   idx_width   : width of a beat index, never less than 1 bit
//   state_t     : decoder control states
package poly_codec_pkg;

   typedef enum logic {IDLE, DRAIN} state_t;

   function automatic int coeff_width(input int output_width, input int scale_factor);
      return output_width + scale_factor;
   endfunction

   function automatic int beats(input int poly_size, input int lanes);
      return poly_size / lanes;
   endfunction

   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/poly_stream_decoder_if.sv
// Handshake bundle for poly_stream_decoder: frame input channel and beat
// output channel, each with its own valid/ready pair.
//   in_valid/in_ready/in_coeff                 : one full frame per handshake
//   out_valid/out_ready/out_data/out_idx/
//   out_last/out_sat                           : one beat of LANES words per handshake
// Modports: slave = decoder side, master = producer/sink side.
interface poly_stream_decoder_if
   import poly_codec_pkg::*;
#(
   parameter int POLY_SIZE    = 16,
   parameter int OUTPUT_WIDTH = 16,
   parameter int SCALE_FACTOR = 2,
   parameter int LANES        = 1
);
   localparam int CW    = coeff_width(OUTPUT_WIDTH, SCALE_FACTOR);
   localparam int IDX_W = idx_width(beats(POLY_SIZE, LANES));

   logic                          in_valid;
   logic                          in_ready;
   logic [CW*POLY_SIZE-1:0]       in_coeff;
   logic                          out_valid;
   logic                          out_ready;
   logic [LANES*OUTPUT_WIDTH-1:0] out_data;
   logic [IDX_W-1:0]              out_idx;
   logic                          out_last;
   logic                          out_sat;

   modport slave (
      input  in_valid, in_coeff, out_ready,
      output in_ready, out_valid, out_data, out_idx, out_last, out_sat
   );

   modport master (
      output in_valid, in_coeff, out_ready,
      input  in_ready, out_valid, out_data, out_idx, out_last, out_sat
   );

endinterface

// File: rtl/poly_coeff_rescale.sv
// One decoder lane: reverse-scales a single coefficient by SCALE_FACTOR.
// Default build truncates (coeff >> SCALE_FACTOR). With DEC_ROUND_EN defined
// the lane rounds half-up and saturates to all-ones on overflow.
//   coeff : scaled coefficient, CW = OUTPUT_WIDTH + SCALE_FACTOR bits
//   word  : decoded OUTPUT_WIDTH-bit word
//   sat   : word was clamped (always 0 unless DEC_ROUND_EN)
// Optional macro: DEC_ROUND_EN.
module poly_coeff_rescale
   import poly_codec_pkg::*;
#(
   parameter  int OUTPUT_WIDTH = 16,
   parameter  int SCALE_FACTOR = 2,
   localparam int CW           = coeff_width(OUTPUT_WIDTH, SCALE_FACTOR)
) (
   input  logic [CW-1:0]           coeff,
   output logic [OUTPUT_WIDTH-1:0] word,
   output logic                    sat
);

`ifdef DEC_ROUND_EN
   // Adding 2^(SF-1) before shifting carries into the kept bits exactly when
   // bit SF-1 of the coefficient is set, so only the kept bits need an adder.
   function automatic logic [OUTPUT_WIDTH:0] round_half_up(
      input logic [OUTPUT_WIDTH-1:0] upper,
      input logic                    half_bit
   );
      return {1'b0, upper} + {{OUTPUT_WIDTH{1'b0}}, half_bit};
   endfunction

   function automatic logic [OUTPUT_WIDTH-1:0] saturate(input logic [OUTPUT_WIDTH:0] r);
      return r[OUTPUT_WIDTH] ? {OUTPUT_WIDTH{1'b1}} : r[OUTPUT_WIDTH-1:0];
   endfunction
`endif

   generate
      if (SCALE_FACTOR == 0) begin : g_pass
         assign word = coeff;
         assign sat  = 1'b0;
      end else begin : g_scale
         // Fraction bits only feed the rounding carry, if anything.
         logic unused_frac;
         assign unused_frac = ^coeff[SCALE_FACTOR-1:0];
`ifdef DEC_ROUND_EN
         logic [OUTPUT_WIDTH:0] rounded;
         assign rounded = round_half_up(coeff[CW-1:SCALE_FACTOR], coeff[SCALE_FACTOR-1]);
         assign word    = saturate(rounded);
         assign sat     = rounded[OUTPUT_WIDTH];
`else
         assign word = coeff[CW-1:SCALE_FACTOR];
         assign sat  = 1'b0;
`endif
      end
   endgenerate

endmodule

// File: rtl/poly_stream_decoder.sv
// Frame-buffered polynomial decoder. Accepts a full frame of POLY_SIZE scaled
// coefficients, then streams them out reverse-scaled, LANES words per beat.
// A new frame may be accepted on the last output handshake so consecutive
// frames stream with no idle cycle.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : poly_stream_decoder_if.slave (frame in, beats out)
// Optional macro: DEC_ROUND_EN (round-half-up + saturate per lane; out_sat).
module poly_stream_decoder
   import poly_codec_pkg::*;
#(
   parameter int POLY_SIZE    = 16,
   parameter int OUTPUT_WIDTH = 16,
   parameter int SCALE_FACTOR = 2,
   parameter int LANES        = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   poly_stream_decoder_if.slave  bus
);
   localparam int CW    = coeff_width(OUTPUT_WIDTH, SCALE_FACTOR);
   localparam int BEATS = beats(POLY_SIZE, LANES);
   localparam int IDX_W = idx_width(BEATS);
   localparam int BW    = LANES * CW;
   localparam int DW    = LANES * OUTPUT_WIDTH;
   localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BEATS - 1);

   state_t           state;
   logic [IDX_W-1:0] beat;
   logic [BW-1:0]    frame_p0 [BEATS];
   logic [DW-1:0]    data_p1;
   logic             last_p1;
   logic             sat_p1;

   logic             accept;
   logic             fire;
   logic [IDX_W-1:0] beat_nxt;
   logic [BW-1:0]    src;
   logic [DW-1:0]    dec;
   logic [LANES-1:0] lane_sat;

   assign fire         = bus.out_valid && bus.out_ready;
   assign bus.in_ready = (state == IDLE) || (fire && last_p1);
   assign accept       = bus.in_valid && bus.in_ready;
   assign beat_nxt     = last_p1 ? '0 : beat + 1'b1;

   // Decoders see the incoming frame's first beat on a capture, otherwise the
   // buffered beat that follows the one currently presented.
   always_comb begin
      src = frame_p0[beat_nxt];
      if (accept) src = bus.in_coeff[BW-1:0];
   end

   genvar l;
   generate
      for (l = 0; l < LANES; l++) begin : g_lane
         poly_coeff_rescale #(
            .OUTPUT_WIDTH (OUTPUT_WIDTH),
            .SCALE_FACTOR (SCALE_FACTOR)
         ) u_rescale (
            .coeff (src[l*CW +: CW]),
            .word  (dec[l*OUTPUT_WIDTH +: OUTPUT_WIDTH]),
            .sat   (lane_sat[l])
         );
      end
   endgenerate

   // p0: frame buffer capture / p1: registered output beat
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         beat    <= '0;
         last_p1 <= 1'b0;
         data_p1 <= '0;
         sat_p1  <= 1'b0;
         for (int b = 0; b < BEATS; b++) frame_p0[b] <= '0;
      end else if (accept) begin
         state   <= DRAIN;
         beat    <= '0;
         last_p1 <= (BEATS == 1);
         data_p1 <= dec;
         sat_p1  <= |lane_sat;
         for (int b = 0; b < BEATS; b++) frame_p0[b] <= bus.in_coeff[b*BW +: BW];
      end else if (fire) begin
         if (last_p1) begin
            state   <= IDLE;
            beat    <= '0;
            last_p1 <= 1'b0;
            sat_p1  <= 1'b0;
         end else begin
            beat    <= beat_nxt;
            last_p1 <= (beat_nxt == LAST_BEAT);
            data_p1 <= dec;
            sat_p1  <= |lane_sat;
         end
      end
   end

   assign bus.out_valid = (state == DRAIN);
   assign bus.out_data  = data_p1;
   assign bus.out_idx   = beat;
   assign bus.out_last  = last_p1;
   assign bus.out_sat   = sat_p1;

endmodule

// File: tb/tb_poly_stream_decoder.sv
// Directed bench for poly_stream_decoder: default 1-lane instance plus a
// 4-lane instance. Expectations follow the DEC_ROUND_EN setting of the build.
module tb_poly_stream_decoder;
   localparam int PS = 16;
   localparam int OW = 16;
   localparam int SF = 2;
   localparam int CW = OW + SF;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   poly_stream_decoder_if #(.POLY_SIZE(PS), .OUTPUT_WIDTH(OW), .SCALE_FACTOR(SF), .LANES(1)) bus ();
   poly_stream_decoder_if #(.POLY_SIZE(PS), .OUTPUT_WIDTH(OW), .SCALE_FACTOR(SF), .LANES(4)) bus4 ();

   poly_stream_decoder #(.POLY_SIZE(PS), .OUTPUT_WIDTH(OW), .SCALE_FACTOR(SF), .LANES(1)) dut (
      .clk (clk), .rst_n (rst_n), .bus (bus.slave));
   poly_stream_decoder #(.POLY_SIZE(PS), .OUTPUT_WIDTH(OW), .SCALE_FACTOR(SF), .LANES(4)) dut4 (
      .clk (clk), .rst_n (rst_n), .bus (bus4.slave));

   logic [CW*PS-1:0] frame;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // coefficient k = 4*(k+base), which decodes to k+base
   task automatic set_ramp(input int base);
      for (int k = 0; k < PS; k++) frame[k*CW +: CW] = CW'(4 * (k + base));
   endtask

   task automatic test_reset();
      bus.in_valid = 1'b0; bus.in_coeff = '0; bus.out_ready = 1'b0;
      bus4.in_valid = 1'b0; bus4.in_coeff = '0; bus4.out_ready = 1'b0;
      rst_n = 1'b0;
      #12;
      vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); end
      vectors++; if (bus.out_data !== 16'h0) begin miscompares++; $display("FAIL reset_out_data got %h want 0", bus.out_data); end
      vectors++; if (bus.out_idx !== 4'd0) begin miscompares++; $display("FAIL reset_out_idx got %0d want 0", bus.out_idx); end
      vectors++; if (bus.out_last !== 1'b0) begin miscompares++; $display("FAIL reset_out_last got %0b want 0", bus.out_last); end
      vectors++; if (bus.out_sat !== 1'b0) begin miscompares++; $display("FAIL reset_out_sat got %0b want 0", bus.out_sat); end
      rst_n = 1'b1;
      #1;
      vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %0b want 1", bus.in_ready); end
      step();
   endtask

   task automatic test_basic();
      set_ramp(0);
      bus.out_ready = 1'b1;
      bus.in_coeff = frame;
      bus.in_valid = 1'b1;
      #1;
      vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_pre_accept_valid got %0b want 0", bus.out_valid); end
      step();
      bus.in_valid = 1'b0;
      for (int b = 0; b < PS; b++) begin
         vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid beat %0d got %0b want 1", b, bus.out_valid); end
         vectors++; if (bus.out_data !== OW'(b)) begin miscompares++; $display("FAIL basic_data beat %0d got %0d want %0d", b, bus.out_data, b); end
         vectors++; if (bus.out_idx !== 4'(b)) begin miscompares++; $display("FAIL basic_idx beat %0d got %0d want %0d", b, bus.out_idx, b); end
         vectors++; if (bus.out_last !== (b == PS - 1)) begin miscompares++; $display("FAIL basic_last beat %0d got %0b want %0b", b, bus.out_last, (b == PS - 1)); end
         step();
      end
      vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_idle_after got %0b want 0", bus.out_valid); end
   endtask

   task automatic test_backpressure();
      logic [15:0] sv_data;
      logic [3:0]  sv_idx;
      logic        sv_last;
      logic        stalled;
      logic        done;
      logic        rdy;
      int          exp_beat;
      set_ramp(0);
      bus.out_ready = 1'b0;
      bus.in_coeff = frame;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      exp_beat = 0; stalled = 1'b0; done = 1'b0;
      sv_data = '0; sv_idx = '0; sv_last = 1'b0;
      for (int cyc = 0; cyc < 300 && !done; cyc++) begin
         if (stalled) begin
            vectors++; if (bus.out_data !== sv_data || bus.out_idx !== sv_idx || bus.out_last !== sv_last) begin
               miscompares++; $display("FAIL stall_hold got %0d/%0d/%0b want %0d/%0d/%0b", bus.out_data, bus.out_idx, bus.out_last, sv_data, sv_idx, sv_last);
            end
         end
         vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid got %0b want 1", bus.out_valid); end
         vectors++; if (bus.out_data !== OW'(exp_beat) || bus.out_idx !== 4'(exp_beat)) begin
            miscompares++; $display("FAIL bp_beat got data %0d idx %0d want %0d", bus.out_data, bus.out_idx, exp_beat);
         end
         vectors++; if (bus.out_last !== (exp_beat == PS - 1)) begin miscompares++; $display("FAIL bp_last got %0b want %0b", bus.out_last, (exp_beat == PS - 1)); end
         rdy = 1'($urandom_range(0, 1));
         bus.out_ready = rdy;
         sv_data = bus.out_data; sv_idx = bus.out_idx; sv_last = bus.out_last;
         stalled = !rdy;
         if (rdy) begin
            if (exp_beat == PS - 1) done = 1'b1;
            exp_beat++;
         end
         step();
      end
      vectors++; if (!done) begin miscompares++; $display("FAIL bp_timeout got %0d beats want %0d", exp_beat, PS); end
      vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_idle_after got %0b want 0", bus.out_valid); end
      bus.out_ready = 1'b1;
   endtask

   task automatic test_back_to_back();
      bus.out_ready = 1'b1;
      set_ramp(0);
      bus.in_coeff = frame;
      bus.in_valid = 1'b1;
      #1;
      vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_idle_ready got %0b want 1", bus.in_ready); end
      step();
      set_ramp(16);
      bus.in_coeff = frame;
      #1;
      for (int b = 0; b < PS; b++) begin
         vectors++; if (bus.out_data !== OW'(b)) begin miscompares++; $display("FAIL b2b_f1_data beat %0d got %0d want %0d", b, bus.out_data, b); end
         vectors++; if (bus.in_ready !== (b == PS - 1)) begin miscompares++; $display("FAIL b2b_in_ready beat %0d got %0b want %0b", b, bus.in_ready, (b == PS - 1)); end
         step();
      end
      bus.in_valid = 1'b0;
      for (int b = 0; b < PS; b++) begin
         vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_f2_valid beat %0d got %0b want 1", b, bus.out_valid); end
         vectors++; if (bus.out_data !== OW'(16 + b) || bus.out_idx !== 4'(b)) begin
            miscompares++; $display("FAIL b2b_f2_beat %0d got data %0d idx %0d want %0d", b, bus.out_data, bus.out_idx, 16 + b);
         end
         step();
      end
      vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_idle_after got %0b want 0", bus.out_valid); end
   endtask

   task automatic test_rounding();
      logic [15:0] exp0;
      logic        exp_sat1;
`ifdef DEC_ROUND_EN
      exp0 = 16'h0002; exp_sat1 = 1'b1;
`else
      exp0 = 16'h0001; exp_sat1 = 1'b0;
`endif
      frame = '0;
      frame[0 +: CW]  = 18'h00006;
      frame[CW +: CW] = 18'h3FFFE;
      bus.out_ready = 1'b1;
      bus.in_coeff = frame;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      vectors++; if (bus.out_data !== exp0) begin miscompares++; $display("FAIL round_small_data got %h want %h", bus.out_data, exp0); end
      vectors++; if (bus.out_sat !== 1'b0) begin miscompares++; $display("FAIL round_small_sat got %0b want 0", bus.out_sat); end
      step();
      vectors++; if (bus.out_data !== 16'hFFFF) begin miscompares++; $display("FAIL round_big_data got %h want ffff", bus.out_data); end
      vectors++; if (bus.out_sat !== exp_sat1) begin miscompares++; $display("FAIL round_big_sat got %0b want %0b", bus.out_sat, exp_sat1); end
      step();
      vectors++; if (bus.out_sat !== 1'b0) begin miscompares++; $display("FAIL round_zero_sat got %0b want 0", bus.out_sat); end
      for (int b = 2; b < PS; b++) step();
      vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL round_idle_after got %0b want 0", bus.out_valid); end
   endtask

   task automatic test_lanes4();
      logic [63:0] exp4;
      set_ramp(0);
      bus4.out_ready = 1'b1;
      bus4.in_coeff = frame;
      bus4.in_valid = 1'b1;
      step();
      bus4.in_valid = 1'b0;
      for (int b = 0; b < 4; b++) begin
         for (int l = 0; l < 4; l++) exp4[l*OW +: OW] = OW'(4 * b + l);
         vectors++; if (bus4.out_valid !== 1'b1) begin miscompares++; $display("FAIL l4_valid beat %0d got %0b want 1", b, bus4.out_valid); end
         vectors++; if (bus4.out_data !== exp4) begin miscompares++; $display("FAIL l4_data beat %0d got %h want %h", b, bus4.out_data, exp4); end
         vectors++; if (bus4.out_idx !== 2'(b)) begin miscompares++; $display("FAIL l4_idx beat %0d got %0d want %0d", b, bus4.out_idx, b); end
         vectors++; if (bus4.out_last !== (b == 3)) begin miscompares++; $display("FAIL l4_last beat %0d got %0b want %0b", b, bus4.out_last, (b == 3)); end
         step();
      end
      vectors++; if (bus4.out_valid !== 1'b0) begin miscompares++; $display("FAIL l4_idle_after got %0b want 0", bus4.out_valid); end
   endtask

   task automatic test_reset_mid();
      int stray;
      set_ramp(0);
      bus.out_ready = 1'b1;
      bus.in_coeff = frame;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      for (int b = 0; b < 5; b++) step();
      vectors++; if (bus.out_idx !== 4'd5) begin miscompares++; $display("FAIL rmid_at_beat got %0d want 5", bus.out_idx); end
      #2;
      rst_n = 1'b0;
      #1;
      vectors++; if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0 || bus.out_idx !== 4'd0 || bus.out_last !== 1'b0 || bus.out_sat !== 1'b0) begin
         miscompares++; $display("FAIL rmid_outputs got v%0b d%0d i%0d l%0b s%0b want all 0", bus.out_valid, bus.out_data, bus.out_idx, bus.out_last, bus.out_sat);
      end
      step();
      rst_n = 1'b1;
      #1;
      vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL rmid_in_ready got %0b want 1", bus.in_ready); end
      stray = 0;
      for (int c = 0; c < 20; c++) begin
         step();
         if (bus.out_valid !== 1'b0) stray++;
      end
      vectors++; if (stray != 0) begin miscompares++; $display("FAIL rmid_stale_beats got %0d want 0", stray); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_back_to_back();
      test_rounding();
      test_lanes4();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
